// File: rtl/imm_decode_stage_if.sv
`default_nettype none
// imm_decode_stage_if: input/output handshake bundle for imm_decode_stage (rev 1.0).
// The master modport is the upstream/downstream side; the slave modport is the stage.
interface imm_decode_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic [XLEN-1:0] out_target;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt, out_target, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt, out_target, out_illegal
  );
endinterface
`default_nettype wire

// File: rtl/imm_decode_stage.sv
`default_nettype none
// imm_decode_stage: registered RISC-V immediate decode with a 2-entry output FIFO (rev 1.0).
// Define IMM_DECODE_ZICSR_EN to decode CSRRWI/CSRRSI/CSRRCI immediates as Z format.
module imm_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush_i,
  imm_decode_stage_if.slave bus
);
  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_decode_stage: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  logic [31:0] ins;
  logic [31:0] imm32;
  logic [2:0]  fmt;
  logic        illegal;
  logic        pcrel;
  entry_t      dec;

  assign ins = bus.in_instr;

  // Every format builds a 32-bit immediate that is then sign-extended to XLEN once.
  always_comb begin
    imm32   = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    pcrel   = 1'b0;
    if (ins[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (ins[6:2])
        5'b00000, 5'b00100, 5'b11001: begin
          fmt   = FMT_I;
          imm32 = {{20{ins[31]}}, ins[31:20]};
        end
        5'b00110: begin
          if (XLEN == 64) begin
            fmt   = FMT_I;
            imm32 = {{20{ins[31]}}, ins[31:20]};
          end else begin
            illegal = 1'b1;
          end
        end
        5'b01000: begin
          fmt   = FMT_S;
          imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        end
        5'b11000: begin
          fmt   = FMT_B;
          pcrel = 1'b1;
          imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        end
        5'b01101: begin
          fmt   = FMT_U;
          imm32 = {ins[31:12], 12'd0};
        end
        5'b00101: begin
          fmt   = FMT_U;
          pcrel = 1'b1;
          imm32 = {ins[31:12], 12'd0};
        end
        5'b11011: begin
          fmt   = FMT_J;
          pcrel = 1'b1;
          imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        end
        5'b01100, 5'b00011: fmt = FMT_NONE;
        5'b01110: illegal = (XLEN != 64);
        5'b11100: begin
`ifdef IMM_DECODE_ZICSR_EN
          if (ins[14]) begin
            fmt   = FMT_Z;
            imm32 = {27'd0, ins[19:15]};
          end
`else
          fmt = FMT_NONE;
`endif
        end
        default: illegal = 1'b1;
      endcase
    end
  end

  always_comb begin
    dec         = '0;
    dec.instr   = ins;
    dec.pc      = bus.in_pc;
    dec.imm     = XLEN'(signed'(imm32));
    dec.fmt     = fmt;
    dec.illegal = illegal;
    dec.target  = pcrel ? (bus.in_pc + XLEN'(signed'(imm32))) : '0;
  end

  entry_t     mem_q [2];
  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic       valid;
  logic       push;
  logic       pop;
  entry_t     head;

  // in_ready looks only at registered occupancy so downstream stalls never reach upstream combinationally.
  assign bus.in_ready = (count_q != 2'd2) && !flush_i;
  assign valid        = (count_q != 2'd0);
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = valid && bus.out_ready;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push) mem_q[wr_ptr_q] <= dec;
    end
  end

  assign head            = valid ? mem_q[rd_ptr_q] : '0;
  assign bus.out_valid   = valid;
  assign bus.out_instr   = head.instr;
  assign bus.out_pc      = head.pc;
  assign bus.out_imm     = head.imm;
  assign bus.out_fmt     = head.fmt;
  assign bus.out_target  = head.target;
  assign bus.out_illegal = head.illegal;
endmodule
`default_nettype wire

// File: tb/tb_imm_decode_stage.sv
`default_nettype none
// tb_imm_decode_stage: table-driven decode vectors on XLEN=32 and XLEN=64 instances,
// plus hand sequences for backpressure, flush and asynchronous reset.
module tb_imm_decode_stage;
  logic clk     = 1'b0;
  logic clk_en  = 1'b0;
  logic reset_n = 1'b0;
  logic flush_i = 1'b0;

  always #5 if (clk_en) clk = ~clk;

  imm_decode_stage_if #(.XLEN(32)) if32 ();
  imm_decode_stage_if #(.XLEN(64)) if64 ();

  imm_decode_stage #(.XLEN(32)) dut32 (.clk(clk), .reset_n(reset_n), .flush_i(flush_i), .bus(if32));
  imm_decode_stage #(.XLEN(64)) dut64 (.clk(clk), .reset_n(reset_n), .flush_i(flush_i), .bus(if64));

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [2:0]  fmt;
    logic [63:0] imm;
    logic [63:0] tgt;
    logic        ill;
    logic        rv64only;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [63:0] pc);
    if32.in_valid = v;
    if32.in_instr = instr;
    if32.in_pc    = pc[31:0];
    if64.in_valid = v;
    if64.in_instr = instr;
    if64.in_pc    = pc;
  endtask

  task automatic set_ready(input logic r);
    if32.out_ready = r;
    if64.out_ready = r;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".v32"},    64'(if32.out_valid),   64'd0);
    check({tag, ".i32"},    64'(if32.out_instr),   64'd0);
    check({tag, ".pc32"},   64'(if32.out_pc),      64'd0);
    check({tag, ".imm32"},  64'(if32.out_imm),     64'd0);
    check({tag, ".fmt32"},  64'(if32.out_fmt),     64'd0);
    check({tag, ".tgt32"},  64'(if32.out_target),  64'd0);
    check({tag, ".ill32"},  64'(if32.out_illegal), 64'd0);
    check({tag, ".v64"},    64'(if64.out_valid),   64'd0);
    check({tag, ".imm64"},  if64.out_imm,          64'd0);
    check({tag, ".tgt64"},  if64.out_target,       64'd0);
  endtask

  localparam logic [31:0] IA = 32'hFFF00093;
  localparam logic [31:0] IB = 32'hFE552C23;
  localparam logic [31:0] IC = 32'h003100B3;
  localparam logic [31:0] IX = 32'h00000463;

  initial begin
    vecs[0]  = '{32'hFE000EE3, 64'h100, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFC, 1'b0, 1'b0};
    vecs[1]  = '{32'h800002B7, 64'h200, 3'd4, 64'hFFFF_FFFF_8000_0000, 64'h0, 1'b0, 1'b0};
    vecs[2]  = '{32'hFFF00093, 64'h4,   3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b0};
    vecs[3]  = '{32'hFE552C23, 64'h8,   3'd2, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 1'b0, 1'b0};
    vecs[4]  = '{32'hFF9FF06F, 64'h1000, 3'd5, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFF8, 1'b0, 1'b0};
    vecs[5]  = '{32'h12345197, 64'h10,  3'd4, 64'h1234_5000, 64'h1234_5010, 1'b0, 1'b0};
    vecs[6]  = '{32'h003100B3, 64'h14,  3'd0, 64'h0, 64'h0, 1'b0, 1'b0};
    vecs[7]  = '{32'h00000010, 64'h18,  3'd0, 64'h0, 64'h0, 1'b1, 1'b0};
    vecs[8]  = '{32'h0000002B, 64'h1C,  3'd0, 64'h0, 64'h0, 1'b1, 1'b0};
    vecs[9]  = '{32'h0010809B, 64'h20,  3'd1, 64'h1, 64'h0, 1'b0, 1'b1};
    vecs[10] = '{32'h002080BB, 64'h24,  3'd0, 64'h0, 64'h0, 1'b0, 1'b1};
`ifdef IMM_DECODE_ZICSR_EN
    vecs[11] = '{32'h3401D073, 64'h28,  3'd6, 64'h3, 64'h0, 1'b0, 1'b0};
`else
    vecs[11] = '{32'h3401D073, 64'h28,  3'd0, 64'h0, 64'h0, 1'b0, 1'b0};
`endif
    vecs[12] = '{32'h010280E7, 64'h2C,  3'd1, 64'h10, 64'h0, 1'b0, 1'b0};
    vecs[13] = '{32'h00000073, 64'h30,  3'd0, 64'h0, 64'h0, 1'b0, 1'b0};
    vecs[14] = '{32'h7FF02083, 64'h34,  3'd1, 64'h7FF, 64'h0, 1'b0, 1'b0};
    vecs[15] = '{32'h00000463, 64'hFFFF_FFFC, 3'd3, 64'h8, 64'h1_0000_0004, 1'b0, 1'b0};

    drive(1'b0, 32'd0, 64'd0);
    set_ready(1'b0);

    // Reset held, clock not yet running
    #2;
    check_idle("rst");
    clk_en = 1'b1;
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst.rdy32", 64'(if32.in_ready), 64'd1);
    check("rst.rdy64", 64'(if64.in_ready), 64'd1);

    // Decode table, one instruction per cycle with out_ready high
    set_ready(1'b1);
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(1'b1, vecs[i].instr, vecs[i].pc);
      @(posedge clk); #1;
      drive(1'b0, 32'd0, 64'd0);
      check($sformatf("v%0d.val64", i), 64'(if64.out_valid),   64'd1);
      check($sformatf("v%0d.ins64", i), 64'(if64.out_instr),   64'(vecs[i].instr));
      check($sformatf("v%0d.pc64",  i), if64.out_pc,           vecs[i].pc);
      check($sformatf("v%0d.fmt64", i), 64'(if64.out_fmt),     64'(vecs[i].fmt));
      check($sformatf("v%0d.imm64", i), if64.out_imm,          vecs[i].imm);
      check($sformatf("v%0d.tgt64", i), if64.out_target,       vecs[i].tgt);
      check($sformatf("v%0d.ill64", i), 64'(if64.out_illegal), 64'(vecs[i].ill));
      check($sformatf("v%0d.val32", i), 64'(if32.out_valid),   64'd1);
      check($sformatf("v%0d.pc32",  i), 64'(if32.out_pc),      64'(vecs[i].pc[31:0]));
      if (vecs[i].rv64only) begin
        check($sformatf("v%0d.fmt32", i), 64'(if32.out_fmt),     64'd0);
        check($sformatf("v%0d.imm32", i), 64'(if32.out_imm),     64'd0);
        check($sformatf("v%0d.tgt32", i), 64'(if32.out_target),  64'd0);
        check($sformatf("v%0d.ill32", i), 64'(if32.out_illegal), 64'd1);
      end else begin
        check($sformatf("v%0d.fmt32", i), 64'(if32.out_fmt),     64'(vecs[i].fmt));
        check($sformatf("v%0d.imm32", i), 64'(if32.out_imm),     64'(vecs[i].imm[31:0]));
        check($sformatf("v%0d.tgt32", i), 64'(if32.out_target),  64'(vecs[i].tgt[31:0]));
        check($sformatf("v%0d.ill32", i), 64'(if32.out_illegal), 64'(vecs[i].ill));
      end
    end
    @(posedge clk); #1;
    check_idle("drain");

    // Backpressure: three back-to-back pushes with out_ready low
    set_ready(1'b0);
    @(negedge clk);
    drive(1'b1, IA, 64'h40);
    check("bp.rdy0", 64'(if32.in_ready), 64'd1);
    @(posedge clk); #1;
    drive(1'b1, IB, 64'h44);
    check("bp.head1", 64'(if32.out_instr), 64'(IA));
    check("bp.rdy1",  64'(if32.in_ready),  64'd1);
    @(posedge clk); #1;
    drive(1'b1, IC, 64'h48);
    check("bp.rdy2",  64'(if32.in_ready),  64'd0);
    check("bp.head2", 64'(if32.out_instr), 64'(IA));
    @(posedge clk); #1;
    check("bp.rdy3",  64'(if32.in_ready),  64'd0);
    check("bp.head3", 64'(if32.out_instr), 64'(IA));
    check("bp.imm3",  64'(if32.out_imm),   64'hFFFF_FFFF);
    check("bp.pc3",   64'(if32.out_pc),    64'h40);
    set_ready(1'b1);
    #1;
    check("bp.rdy_nocomb", 64'(if32.in_ready), 64'd0);
    @(posedge clk); #1;
    check("bp.head4", 64'(if32.out_instr), 64'(IB));
    check("bp.pc4",   64'(if32.out_pc),    64'h44);
    check("bp.rdy4",  64'(if32.in_ready),  64'd1);
    @(posedge clk); #1;
    drive(1'b0, 32'd0, 64'd0);
    check("bp.head5", 64'(if32.out_instr), 64'(IC));
    check("bp.pc5",   64'(if32.out_pc),    64'h48);
    check("bp.fmt5",  64'(if32.out_fmt),   64'd0);
    @(posedge clk); #1;
    check("bp.empty", 64'(if32.out_valid), 64'd0);

    // Flush with a full buffer and a pending input
    set_ready(1'b0);
    @(negedge clk);
    drive(1'b1, IA, 64'h50);
    @(posedge clk); #1;
    drive(1'b1, IB, 64'h54);
    @(posedge clk); #1;
    drive(1'b1, IX, 64'h58);
    flush_i = 1'b1;
    #1;
    check("fl.rdy32", 64'(if32.in_ready), 64'd0);
    check("fl.val32", 64'(if32.out_valid), 64'd1);
    @(posedge clk); #1;
    flush_i = 1'b0;
    drive(1'b0, 32'd0, 64'd0);
    check_idle("fl.after");
    set_ready(1'b1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("fl.gone%0d", k), 64'(if32.out_valid), 64'd0);
    end

    // Flush with an empty buffer still refuses the same-cycle input
    @(negedge clk);
    drive(1'b1, IX, 64'h60);
    flush_i = 1'b1;
    #1;
    check("fl0.rdy32", 64'(if32.in_ready), 64'd0);
    check("fl0.rdy64", 64'(if64.in_ready), 64'd0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    drive(1'b0, 32'd0, 64'd0);
    check("fl0.val32", 64'(if32.out_valid), 64'd0);
    check("fl0.val64", 64'(if64.out_valid), 64'd0);

    // Asynchronous reset in the middle of operation
    set_ready(1'b0);
    @(negedge clk);
    drive(1'b1, IA, 64'h70);
    @(posedge clk); #1;
    drive(1'b0, 32'd0, 64'd0);
    check("ar.pre", 64'(if32.out_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check_idle("ar");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("ar.rdy32", 64'(if32.in_ready), 64'd1);
    check("ar.val32", 64'(if32.out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
